// File: rtl/if_layer_tm_if.sv
// -----------------------------------------------------------------------------
// if_layer_tm_if
// Bundles the control, weight-load and result signals of if_layer_tm.
//   start      : begin a timestep (honoured only while the layer is idle)
//   spike_in   : input spike vector, latched when start is accepted
//   clr        : idle-only clear of all potentials and refractory counters
//   w_we       : weight row write strobe
//   w_addr     : weight row index
//   w_data     : one row of weights, neuron j at [j*WEIGHT_SIZE +: WEIGHT_SIZE]
//   busy       : timestep in progress
//   done       : one-cycle pulse, spike_out freshly valid
//   spike_out  : output spikes of the last completed timestep
// The master drives requests and weights; the slave (the layer) answers.
// -----------------------------------------------------------------------------
interface if_layer_tm_if #(
   parameter int NUM_INPUTS  = 784,
   parameter int NUM_OUTPUTS = 100,
   parameter int WEIGHT_SIZE = 4
);
   localparam int ADDR_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

   logic                               start;
   logic [NUM_INPUTS-1:0]              spike_in;
   logic                               clr;
   logic                               w_we;
   logic [ADDR_W-1:0]                  w_addr;
   logic [NUM_OUTPUTS*WEIGHT_SIZE-1:0] w_data;
   logic                               busy;
   logic                               done;
   logic [NUM_OUTPUTS-1:0]             spike_out;

   modport master (
      output start, spike_in, clr, w_we, w_addr, w_data,
      input  busy, done, spike_out
   );

   modport slave (
      input  start, spike_in, clr, w_we, w_addr, w_data,
      output busy, done, spike_out
   );
endinterface

// File: rtl/if_layer_tm.sv
// -----------------------------------------------------------------------------
// if_layer_tm
// Time-multiplexed integrate-and-fire neuron layer. Each accepted start runs
// one timestep: the latched input spikes are scanned one row per cycle, every
// active row adds its signed weights (sign-extended, shifted by WEIGHT_SHIFT)
// into all membrane potentials with saturation, then a single FIRE cycle
// applies threshold / reset / refractory / leak and registers spike_out.
// Latency from accepted start to done is NUM_INPUTS+2 cycles.
//
// Ports
//   clk  : clock, everything on the rising edge
//   rst  : synchronous active-high reset (weights are kept)
//   bus  : if_layer_tm_if slave modport (start, spike_in, clr, weight write
//          port, busy, done, spike_out)
// -----------------------------------------------------------------------------
module if_layer_tm #(
   parameter int     NUM_INPUTS   = 784,
   parameter int     NUM_OUTPUTS  = 100,
   parameter int     WEIGHT_SIZE  = 4,
   parameter int     WEIGHT_SHIFT = 32,
   parameter int     POT_WIDTH    = 36,
   parameter longint THRESH       = 64'sd25769803776,
   parameter longint RESET        = 64'sd10737418240,
   parameter int     REFRAC       = 5,
   parameter int     LEAK_SHIFT   = 0
) (
   input logic          clk,
   input logic          rst,
   if_layer_tm_if.slave bus
);

   localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
   localparam int REF_W = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
   localparam int SHW   = WEIGHT_SIZE + WEIGHT_SHIFT;
   // One guard bit above the wider of potential and shifted weight so the
   // raw sum can never wrap before it is clamped.
   localparam int SUM_W = ((POT_WIDTH > SHW) ? POT_WIDTH : SHW) + 1;

   localparam logic signed [POT_WIDTH-1:0] C_PMAX   = {1'b0, {(POT_WIDTH-1){1'b1}}};
   localparam logic signed [POT_WIDTH-1:0] C_PMIN   = {1'b1, {(POT_WIDTH-1){1'b0}}};
   localparam logic signed [SUM_W-1:0]     C_SMAX   = {{(SUM_W-POT_WIDTH+1){1'b0}}, {(POT_WIDTH-1){1'b1}}};
   localparam logic signed [SUM_W-1:0]     C_SMIN   = {{(SUM_W-POT_WIDTH+1){1'b1}}, {(POT_WIDTH-1){1'b0}}};
   localparam logic signed [POT_WIDTH-1:0] C_THRESH = POT_WIDTH'(THRESH);
   localparam logic signed [POT_WIDTH-1:0] C_RESET  = POT_WIDTH'(RESET);
   localparam logic [REF_W-1:0]            C_REFRAC = REF_W'(REFRAC);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SCAN,
      S_FIRE
   } state_t;

   state_t                              r_state;
   state_t                              w_state_nxt;
   logic [IDX_W-1:0]                    r_idx;
   logic [NUM_INPUTS-1:0]               r_spk;
   logic signed [POT_WIDTH-1:0]         r_v      [NUM_OUTPUTS];
   logic [REF_W-1:0]                    r_refrac [NUM_OUTPUTS];
   logic [NUM_OUTPUTS-1:0]              r_spike_out;
   logic                                r_done;
   logic [NUM_OUTPUTS*WEIGHT_SIZE-1:0]  r_wmem   [NUM_INPUTS];

   logic [NUM_OUTPUTS*WEIGHT_SIZE-1:0]  w_row;
   logic signed [POT_WIDTH-1:0]         w_acc    [NUM_OUTPUTS];
   logic signed [POT_WIDTH-1:0]         w_leak   [NUM_OUTPUTS];
   logic [NUM_OUTPUTS-1:0]              w_fire;

   // ---------------------------------------------------------------------------
   // Weight memory: written only while idle, read one row per SCAN cycle.
   // ---------------------------------------------------------------------------
   // NOTE: the weight array deliberately has no reset branch; weights survive
   // rst and clr, and leaving it out keeps the array a plain register file.
   always_ff @(posedge clk) begin
      if (bus.w_we && (r_state == S_IDLE) && (32'(bus.w_addr) < NUM_INPUTS)) begin
         r_wmem[bus.w_addr] <= bus.w_data;
      end
   end

   assign w_row = r_wmem[r_idx];

   // ---------------------------------------------------------------------------
   // Per-neuron datapath: saturating accumulate, leak and fire decision.
   // ---------------------------------------------------------------------------
   always_comb begin
      for (int j = 0; j < NUM_OUTPUTS; j++) begin
         logic signed [WEIGHT_SIZE-1:0] v_w;
         logic signed [SUM_W-1:0]       v_sum;
         v_w   = w_row[j*WEIGHT_SIZE +: WEIGHT_SIZE];
         v_sum = SUM_W'(r_v[j]) + (SUM_W'(v_w) <<< WEIGHT_SHIFT);
         if (v_sum > C_SMAX) begin
            w_acc[j] = C_PMAX;
         end else if (v_sum < C_SMIN) begin
            w_acc[j] = C_PMIN;
         end else begin
            w_acc[j] = POT_WIDTH'(v_sum);
         end
         // Arithmetic shift rounds toward minus infinity, so a leaking
         // negative potential decays toward zero without overshooting it.
         w_leak[j] = r_v[j] - (r_v[j] >>> LEAK_SHIFT);
         w_fire[j] = (r_refrac[j] == '0) && (r_v[j] >= C_THRESH);
      end
   end

   // ---------------------------------------------------------------------------
   // FSM next-state logic.
   // ---------------------------------------------------------------------------
   // NOTE: every combinational output gets a default before the case so that
   // no path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (bus.start && !bus.clr) w_state_nxt = S_SCAN;
         S_SCAN:  if (r_idx == IDX_W'(NUM_INPUTS - 1)) w_state_nxt = S_FIRE;
         S_FIRE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // State register and neuron state update.
   // ---------------------------------------------------------------------------
   // NOTE: all clocked state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_idx       <= '0;
         r_spk       <= '0;
         r_spike_out <= '0;
         r_done      <= 1'b0;
         for (int j = 0; j < NUM_OUTPUTS; j++) begin
            r_v[j]      <= '0;
            r_refrac[j] <= '0;
         end
      end else begin
         r_state <= w_state_nxt;
         r_done  <= (r_state == S_FIRE);
         case (r_state)
            S_IDLE: begin
               if (bus.clr) begin
                  for (int j = 0; j < NUM_OUTPUTS; j++) begin
                     r_v[j]      <= '0;
                     r_refrac[j] <= '0;
                  end
               end else if (bus.start) begin
                  r_spk <= bus.spike_in;
                  r_idx <= '0;
               end
            end
            S_SCAN: begin
               if (r_spk[r_idx]) begin
                  for (int j = 0; j < NUM_OUTPUTS; j++) begin
                     // Refractory neurons ignore input for the whole timestep.
                     if (r_refrac[j] == '0) r_v[j] <= w_acc[j];
                  end
               end
               r_idx <= r_idx + 1'b1;
            end
            S_FIRE: begin
               r_spike_out <= w_fire;
               for (int j = 0; j < NUM_OUTPUTS; j++) begin
                  if (r_refrac[j] != '0) begin
                     r_refrac[j] <= r_refrac[j] - 1'b1;
                  end else if (w_fire[j]) begin
                     r_v[j]      <= C_RESET;
                     r_refrac[j] <= C_REFRAC;
                  end else if (LEAK_SHIFT > 0) begin
                     r_v[j] <= w_leak[j];
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy      = (r_state != S_IDLE);
   assign bus.done      = r_done;
   assign bus.spike_out = r_spike_out;

endmodule

// File: tb/tb_if_layer_tm.sv
// -----------------------------------------------------------------------------
// tb_if_layer_tm
// Three small layers (base, large weight shift, leaky) driven one at a time
// and compared against an arithmetic reference model of the neuron rules.
// -----------------------------------------------------------------------------
module tb_if_layer_tm;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       t_start [3];
   logic       t_clr   [3];
   logic       t_we    [3];
   logic [3:0] t_spk   [3];
   logic [1:0] t_addr  = '0;
   logic [7:0] t_wdata = '0;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   if_layer_tm_if #(.NUM_INPUTS(4), .NUM_OUTPUTS(2), .WEIGHT_SIZE(4)) if0 ();
   if_layer_tm_if #(.NUM_INPUTS(4), .NUM_OUTPUTS(2), .WEIGHT_SIZE(4)) if1 ();
   if_layer_tm_if #(.NUM_INPUTS(4), .NUM_OUTPUTS(2), .WEIGHT_SIZE(4)) if2 ();

   assign if0.start = t_start[0];  assign if0.clr = t_clr[0];  assign if0.w_we = t_we[0];
   assign if1.start = t_start[1];  assign if1.clr = t_clr[1];  assign if1.w_we = t_we[1];
   assign if2.start = t_start[2];  assign if2.clr = t_clr[2];  assign if2.w_we = t_we[2];
   assign if0.spike_in = t_spk[0]; assign if1.spike_in = t_spk[1]; assign if2.spike_in = t_spk[2];
   assign if0.w_addr = t_addr;     assign if1.w_addr = t_addr;     assign if2.w_addr = t_addr;
   assign if0.w_data = t_wdata;    assign if1.w_data = t_wdata;    assign if2.w_data = t_wdata;

   if_layer_tm #(.NUM_INPUTS(4), .NUM_OUTPUTS(2), .WEIGHT_SIZE(4), .WEIGHT_SHIFT(0),
      .POT_WIDTH(16), .THRESH(6), .RESET(2), .REFRAC(2), .LEAK_SHIFT(0))
      dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
   if_layer_tm #(.NUM_INPUTS(4), .NUM_OUTPUTS(2), .WEIGHT_SIZE(4), .WEIGHT_SHIFT(12),
      .POT_WIDTH(16), .THRESH(6), .RESET(2), .REFRAC(2), .LEAK_SHIFT(0))
      dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
   if_layer_tm #(.NUM_INPUTS(4), .NUM_OUTPUTS(2), .WEIGHT_SIZE(4), .WEIGHT_SHIFT(0),
      .POT_WIDTH(16), .THRESH(100), .RESET(2), .REFRAC(2), .LEAK_SHIFT(1))
      dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

   // ---------------------------------------------------------------- model
   int         cfg_ws [3] = '{0, 12, 0};
   int         cfg_th [3] = '{6, 6, 100};
   int         cfg_ls [3] = '{0, 0, 1};
   int         m_w    [3][4][2];
   int         m_v    [3][2];
   int         m_r    [3][2];
   logic [1:0] m_so   [3];
   int         exp_so [6] = '{0, 1, 0, 0, 0, 1};
   int         pk     [6] = '{0, 0, 0, 1, 2, 4};

   function automatic int floor_div(int a, int d);
      int q;
      q = a / d;
      if ((a % d) != 0 && a < 0) q = q - 1;
      return q;
   endfunction

   function automatic void model_reset();
      for (int k = 0; k < 3; k++) begin
         m_so[k] = '0;
         for (int j = 0; j < 2; j++) begin
            m_v[k][j] = 0;
            m_r[k][j] = 0;
         end
      end
   endfunction

   function automatic void model_step(int k, logic [3:0] s);
      longint     x;
      logic [1:0] so;
      so = '0;
      for (int i = 0; i < 4; i++) begin
         if (s[i]) begin
            for (int j = 0; j < 2; j++) begin
               if (m_r[k][j] == 0) begin
                  x = longint'(m_v[k][j]) + longint'(m_w[k][i][j]) * (longint'(1) << cfg_ws[k]);
                  if (x > 32767)  x = 32767;
                  if (x < -32768) x = -32768;
                  m_v[k][j] = int'(x);
               end
            end
         end
      end
      for (int j = 0; j < 2; j++) begin
         if (m_r[k][j] > 0) begin
            m_r[k][j] = m_r[k][j] - 1;
         end else if (m_v[k][j] >= cfg_th[k]) begin
            so[j]     = 1'b1;
            m_v[k][j] = 2;
            m_r[k][j] = 2;
         end else if (cfg_ls[k] > 0) begin
            m_v[k][j] = m_v[k][j] - floor_div(m_v[k][j], 1 << cfg_ls[k]);
         end
      end
      m_so[k] = so;
   endfunction

   // ---------------------------------------------------------------- access
   function automatic logic get_busy(int k);
      case (k)
         0:       return if0.busy;
         1:       return if1.busy;
         default: return if2.busy;
      endcase
   endfunction

   function automatic logic get_done(int k);
      case (k)
         0:       return if0.done;
         1:       return if1.done;
         default: return if2.done;
      endcase
   endfunction

   function automatic logic [1:0] get_so(int k);
      case (k)
         0:       return if0.spike_out;
         1:       return if1.spike_out;
         default: return if2.spike_out;
      endcase
   endfunction

   function automatic int get_v(int k, int j);
      case (k)
         0:       return int'(dut0.r_v[j]);
         1:       return int'(dut1.r_v[j]);
         default: return int'(dut2.r_v[j]);
      endcase
   endfunction

   task automatic check(string tag, longint got, longint exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // ---------------------------------------------------------------- drivers
   task automatic wr(int k, int row, int d0, int d1);
      @(negedge clk);
      t_we[k] = 1'b1;
      t_addr  = 2'(row);
      t_wdata = {4'(d1), 4'(d0)};
      @(negedge clk);
      t_we[k] = 1'b0;
      m_w[k][row][0] = d0;
      m_w[k][row][1] = d1;
   endtask

   task automatic do_rst(int ncyc);
      @(negedge clk);
      rst = 1'b1;
      repeat (ncyc) @(negedge clk);
      rst = 1'b0;
      model_reset();
      for (int k = 0; k < 3; k++) begin
         check($sformatf("rst_busy%0d", k), get_busy(k), 0);
         check($sformatf("rst_done%0d", k), get_done(k), 0);
         check($sformatf("rst_so%0d", k), get_so(k), 0);
         check($sformatf("rst_v%0d", k), get_v(k, 0), 0);
      end
   endtask

   task automatic clr_test(int k);
      @(negedge clk);
      t_clr[k]   = 1'b1;
      t_start[k] = 1'b1;
      t_spk[k]   = 4'hF;
      @(negedge clk);
      t_clr[k]   = 1'b0;
      t_start[k] = 1'b0;
      for (int j = 0; j < 2; j++) begin
         m_v[k][j] = 0;
         m_r[k][j] = 0;
      end
      check($sformatf("clr_busy%0d", k), get_busy(k), 0);
      for (int j = 0; j < 2; j++) check($sformatf("clr_v%0d_%0d", k, j), get_v(k, j), 0);
   endtask

   // poke: 0 none, 1 start at cycle 3, 2 weight write at cycle 3,
   //       3 rst at cycle 3, 4 back-to-back start in the done cycle
   task automatic run_ts(int k, logic [3:0] s, int poke);
      int   busy_bad;
      int   done_bad;
      logic eb;
      logic ed;
      busy_bad = 0;
      done_bad = 0;
      @(negedge clk);
      t_start[k] = 1'b1;
      t_spk[k]   = s;
      @(posedge clk);
      #1;
      t_start[k] = 1'b0;
      t_spk[k]   = ~s;
      if (poke == 3) model_reset();
      else           model_step(k, s);
      for (int n = 1; n <= 12; n++) begin
         @(negedge clk);
         if (poke == 3) begin
            eb = (n <= 3);
            ed = 1'b0;
         end else begin
            eb = (n <= 5) || (poke == 4 && n >= 7 && n <= 11);
            ed = (n == 6) || (poke == 4 && n == 12);
         end
         if (get_busy(k) !== eb) busy_bad++;
         if (get_done(k) !== ed) done_bad++;
         if (n == 6 && poke != 3) begin
            check($sformatf("so_done%0d", k), get_so(k), m_so[k]);
            if (poke == 4) model_step(k, s);
         end
         if (n == 3) begin
            case (poke)
               1: t_start[k] = 1'b1;
               2: begin t_we[k] = 1'b1; t_addr = 2'd0; t_wdata = 8'h77; end
               3: rst = 1'b1;
               default: ;
            endcase
         end
         if (n == 4) begin
            t_start[k] = 1'b0;
            t_we[k]    = 1'b0;
            rst        = 1'b0;
         end
         if (poke == 4 && n == 6) begin
            t_start[k] = 1'b1;
            t_spk[k]   = s;
         end
         if (poke == 4 && n == 7) begin
            t_start[k] = 1'b0;
            t_spk[k]   = ~s;
         end
      end
      check($sformatf("busy_seq%0d", k), busy_bad, 0);
      check($sformatf("done_seq%0d", k), done_bad, 0);
      check($sformatf("so_hold%0d", k), get_so(k), m_so[k]);
      for (int j = 0; j < 2; j++) check($sformatf("v%0d_%0d", k, j), get_v(k, j), m_v[k][j]);
   endtask

   // ---------------------------------------------------------------- sequence
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      for (int k = 0; k < 3; k++) begin
         t_start[k] = 1'b0;
         t_clr[k]   = 1'b0;
         t_we[k]    = 1'b0;
         t_spk[k]   = '0;
         for (int i = 0; i < 4; i++) begin
            m_w[k][i][0] = 0;
            m_w[k][i][1] = 0;
         end
      end
      model_reset();

      // reset values, then an empty timestep with the nominal timing
      do_rst(2);
      run_ts(0, 4'b0000, 0);

      // weights for the three layers
      wr(0, 0, 3, -1);
      wr(1, 0, -8, 0);
      wr(2, 0, 4, 0);
      for (int k = 0; k < 3; k++)
         for (int r = 1; r < 4; r++) wr(k, r, 0, 0);

      // integrate/fire then refractory window
      for (int t = 0; t < 6; t++) begin
         run_ts(0, 4'b0001, 0);
         check($sformatf("ip_so_t%0d", t), get_so(0), exp_so[t]);
         if (t == 1) begin
            check("ip_v0", get_v(0, 0), 2);
            check("ip_v1", get_v(0, 1), -2);
         end
         if (t == 4) check("ref_v0", get_v(0, 0), 5);
      end

      // clr clears refractory state: next timestep integrates again
      clr_test(0);
      run_ts(0, 4'b0001, 0);
      check("clr_int_v0", get_v(0, 0), 3);

      // saturation
      for (int t = 0; t < 2; t++) begin
         run_ts(1, 4'b0001, 0);
         check("sat_v0", get_v(1, 0), -32768);
         check("sat_so", get_so(1), 0);
      end

      // leak
      run_ts(2, 4'b0001, 0);
      check("leak_v0_a", get_v(2, 0), 2);
      run_ts(2, 4'b0000, 0);
      check("leak_v0_b", get_v(2, 0), 1);
      run_ts(2, 4'b0000, 0);
      check("leak_v0_c", get_v(2, 0), 1);

      // protocol
      run_ts(0, 4'b0001, 1);
      run_ts(0, 4'b0001, 2);
      run_ts(0, 4'b0001, 0);
      run_ts(0, 4'b0001, 4);
      run_ts(0, 4'b0001, 3);
      check("rst_abort_v0", get_v(0, 0), 0);

      // randomized traffic on every layer
      for (int k = 0; k < 3; k++) begin
         for (int t = 0; t < 25; t++) begin
            if ($urandom_range(0, 1) == 1)
               wr(k, int'($urandom_range(0, 3)), int'($urandom_range(0, 15)) - 8,
                  int'($urandom_range(0, 15)) - 8);
            if ($urandom_range(0, 9) == 0) clr_test(k);
            run_ts(k, 4'($urandom_range(0, 15)), pk[$urandom_range(0, 5)]);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
